// File: rtl/mdr_unit.sv
`default_nettype none
// ============================================================================
//  mdr_unit
//  Memory data register with a read/write handshake engine, ack timeout and
//  byte/half/word sizing with sign or zero extension on loads.
//  Revision: 1.0
// ============================================================================
module mdr_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   bus_in,
    input  logic                mdr_in,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mdr_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mdr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              done_q;
    logic              err_q;

    logic [DATA_W-1:0] rdata_ext_d;
    logic [BE_W-1:0]   be_d;
    logic              timeout_d;

    // Sized load value: bits above the selected field take its top bit or zero.
    always_comb begin
        rdata_ext_d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (size_q == 2'd0)
                rdata_ext_d[i] = (i < 8)  ? mem_rdata[i] : (sext_q & mem_rdata[7]);
            else if (size_q == 2'd1)
                rdata_ext_d[i] = (i < 16) ? mem_rdata[i] : (sext_q & mem_rdata[15]);
            else
                rdata_ext_d[i] = mem_rdata[i];
        end
    end

    always_comb begin
        be_d = '0;
        for (int i = 0; i < BE_W; i++)
            be_d[i] = (i == 0) || ((i == 1) && (size_q != 2'd0)) || size_q[1];
    end

    // The counter holds the number of completed wait cycles; the TIMEOUT-th ends the wait.
    assign timeout_d = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mdr_q   <= '0;
            cnt_q   <= '0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mdr_in) begin
                        mdr_q <= bus_in;
                    end else if (rd_req) begin
                        state_q <= S_READ;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (wr_req) begin
                        state_q <= S_WRITE;
                        size_q  <= size;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_READ, S_WRITE: begin
                    if (mem_ack) begin
                        if (state_q == S_READ)
                            mdr_q <= rdata_ext_d;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (timeout_d) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_READ) || (state_q == S_WRITE);
    assign mem_rd    = (state_q == S_READ);
    assign mem_wr    = (state_q == S_WRITE);
    assign mem_be    = busy ? be_d : '0;
    assign mem_wdata = mdr_q;
    assign mdr_out   = mdr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mdr_unit.sv
`default_nettype none
// ============================================================================
//  tb_mdr_unit
//  Directed vector table plus hand-written corner sequences for mdr_unit.
//  Revision: 1.0
// ============================================================================
module tb_mdr_unit;

    logic        clock;
    logic        reset;
    logic [31:0] bus_in;
    logic        mdr_in;
    logic        rd_req;
    logic        wr_req;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mdr_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mdr_unit #(.DATA_W(32), .TIMEOUT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus_in    (bus_in),
        .mdr_in    (mdr_in),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .size      (size),
        .sign_ext  (sign_ext),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mdr_out   (mdr_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mdr_in  = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        mem_ack = 1'b0;
    endtask

    // op: 0 = bus load, 1 = read, 2 = write
    typedef struct {
        logic [1:0]  op;
        logic [31:0] bus;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] exp_mdr;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{2'd0, 32'h1111_2222, 2'd0, 1'b0, 32'h0,          0, 32'h1111_2222, 4'h0};
        vecs[1]  = '{2'd1, 32'h0,         2'd0, 1'b1, 32'h1234_5680,  3, 32'hFFFF_FF80, 4'h1};
        vecs[2]  = '{2'd1, 32'h0,         2'd1, 1'b0, 32'hABCD_8001,  0, 32'h0000_8001, 4'h3};
        vecs[3]  = '{2'd1, 32'h0,         2'd0, 1'b0, 32'h7777_77F0,  1, 32'h0000_00F0, 4'h1};
        vecs[4]  = '{2'd1, 32'h0,         2'd1, 1'b1, 32'hFFFF_7FFF,  2, 32'h0000_7FFF, 4'h3};
        vecs[5]  = '{2'd1, 32'h0,         2'd1, 1'b1, 32'h1234_9ABC,  0, 32'hFFFF_9ABC, 4'h3};
        vecs[6]  = '{2'd1, 32'h0,         2'd3, 1'b1, 32'hCAFE_F00D,  1, 32'hCAFE_F00D, 4'hF};
        vecs[7]  = '{2'd0, 32'hDEAD_BEEF, 2'd0, 1'b0, 32'h0,          0, 32'hDEAD_BEEF, 4'h0};
        vecs[8]  = '{2'd2, 32'h0,         2'd2, 1'b0, 32'h5555_5555,  2, 32'hDEAD_BEEF, 4'hF};
        vecs[9]  = '{2'd2, 32'h0,         2'd0, 1'b1, 32'h0,          0, 32'hDEAD_BEEF, 4'h1};
        vecs[10] = '{2'd2, 32'h0,         2'd1, 1'b0, 32'h0,          1, 32'hDEAD_BEEF, 4'h3};

        idle_inputs();
        bus_in    = '0;
        size      = 2'd0;
        sign_ext  = 1'b0;
        mem_rdata = '0;
        reset     = 1'b0;
        #12;
        chk("reset_mdr",   mdr_out,   32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        chk("reset_ctl",   {28'h0, mem_rd, mem_wr, busy, done}, 32'h0);
        chk("reset_be",    {28'h0, mem_be}, 32'h0);
        chk("reset_err",   {31'h0, err}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        step();

        for (int v = 0; v < 11; v++) begin
            bus_in   = vecs[v].bus;
            size     = vecs[v].sz;
            sign_ext = vecs[v].sx;
            mdr_in   = (vecs[v].op == 2'd0);
            rd_req   = (vecs[v].op == 2'd1);
            wr_req   = (vecs[v].op == 2'd2);
            step();
            idle_inputs();
            if (vecs[v].op == 2'd0) begin
                chk($sformatf("v%0d_load_mdr", v), mdr_out, vecs[v].exp_mdr);
                chk($sformatf("v%0d_load_busy", v), {31'h0, busy}, 32'h0);
            end else begin
                for (int d = 0; d <= vecs[v].dly; d++) begin
                    chk($sformatf("v%0d_w%0d_be", v, d), {28'h0, mem_be}, {28'h0, vecs[v].exp_be});
                    chk($sformatf("v%0d_w%0d_strb", v, d), {29'h0, busy, mem_rd, mem_wr},
                        {29'h0, 1'b1, vecs[v].op == 2'd1, vecs[v].op == 2'd2});
                    chk($sformatf("v%0d_w%0d_done", v, d), {31'h0, done}, 32'h0);
                    if (vecs[v].op == 2'd2)
                        chk($sformatf("v%0d_w%0d_wdata", v, d), mem_wdata, vecs[v].exp_mdr);
                    if (d < vecs[v].dly)
                        step();
                end
                mem_ack   = 1'b1;
                mem_rdata = vecs[v].rdata;
                step();
                mem_ack   = 1'b0;
                mem_rdata = 32'hA5A5_A5A5;
                chk($sformatf("v%0d_mdr", v), mdr_out, vecs[v].exp_mdr);
                chk($sformatf("v%0d_done", v), {30'h0, done, busy}, 32'h2);
                chk($sformatf("v%0d_idle_be", v), {28'h0, mem_be}, 32'h0);
                step();
                chk($sformatf("v%0d_done_gone", v), {30'h0, done, err}, 32'h0);
            end
        end

        // Priority: all three commands together only load the bus value.
        bus_in = 32'h55AA_55AA; mdr_in = 1'b1; rd_req = 1'b1; wr_req = 1'b1; size = 2'd2;
        step();
        idle_inputs();
        chk("prio_mdr",  mdr_out, 32'h55AA_55AA);
        chk("prio_busy", {30'h0, busy, mem_rd}, 32'h0);

        // Ack in IDLE is ignored.
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_mdr",  mdr_out, 32'h55AA_55AA);
        chk("idle_ack_done", {30'h0, done, busy}, 32'h0);

        // Commands during WRITE are ignored.
        wr_req = 1'b1; size = 2'd2;
        step();
        wr_req = 1'b0; rd_req = 1'b1; mdr_in = 1'b1; bus_in = 32'h1357_9BDF;
        step();
        idle_inputs();
        chk("busy_ign_strb", {30'h0, mem_wr, mem_rd}, 32'h2);
        chk("busy_ign_mdr",  mdr_out, 32'h55AA_55AA);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        chk("busy_ign_done", {31'h0, done}, 32'h1);
        chk("busy_ign_keep", mdr_out, 32'h55AA_55AA);
        step();
        chk("busy_ign_no_rd", {30'h0, busy, mem_rd}, 32'h0);

        // Timeout: abort exactly at request edge + 15.
        rd_req = 1'b1; size = 2'd2;
        step();
        rd_req = 1'b0;
        for (int c = 1; c < 15; c++) step();
        chk("to_pre_busy", {30'h0, busy, err}, 32'h2);
        step();
        chk("to_abort", {29'h0, busy, err, done}, 32'h2);
        chk("to_mdr",   mdr_out, 32'h55AA_55AA);
        step();
        mdr_in = 1'b1; bus_in = 32'h0000_0042;
        step();
        mdr_in = 1'b0;
        chk("to_err_sticky", {31'h0, err}, 32'h1);
        wr_req = 1'b1; size = 2'd0;
        step();
        wr_req = 1'b0;
        chk("to_err_clear", {30'h0, busy, err}, 32'h2);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("to_wr_done", {31'h0, done}, 32'h1);

        // Ack on the 15th wait edge wins over the timeout.
        rd_req = 1'b1; size = 2'd0; sign_ext = 1'b1;
        step();
        rd_req = 1'b0;
        for (int c = 1; c < 15; c++) step();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0081;
        step();
        mem_ack = 1'b0;
        chk("to_edge_done", {30'h0, done, err}, 32'h2);
        chk("to_edge_mdr",  mdr_out, 32'hFFFF_FF81);

        // Reset during a read drops the transaction immediately.
        step();
        rd_req = 1'b1; size = 2'd2;
        step();
        rd_req = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_ctl", {29'h0, mem_rd, busy, done}, 32'h0);
        chk("rst_mid_mdr", mdr_out, 32'h0);
        step();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rst_mid_nodone%0d", c), {30'h0, done, busy}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdr_unit.md
# mdr_unit

Parametrised memory data register with a built-in memory handshake engine. It generalises the plain bus/memory-select MDR: it loads from the CPU bus, runs read and write transactions to memory with ack handshake and timeout, and performs byte/half/word sizing with sign or zero extension on loads. It sits between the internal bus (`bus_in`/`mdr_out`) and the memory port, with the control unit driving the request strobes.

## Interface

Parameters:
- `DATA_W`, default 32: data width; multiple of 8, at least 16.
- `TIMEOUT`, default 15: number of wait cycles without `mem_ack` before a transaction aborts; at least 1.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bus_in`  in  DATA_W  bus value loaded by `mdr_in`.
- `mdr_in`  in  1  load `bus_in` into the MDR.
- `rd_req`  in  1  start a memory read into the MDR.
- `wr_req`  in  1  start a memory write of the MDR.
- `size`  in  2  access size: 0 is byte, 1 is half, 2 or 3 is full `DATA_W`.
- `sign_ext`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  memory completion strobe.
- `mem_rd`  out  1  read strobe, held until ack or timeout.
- `mem_wr`  out  1  write strobe, held until ack or timeout.
- `mem_wdata`  out  DATA_W  write data; equals the MDR contents.
- `mem_be`  out  DATA_W/8  byte enables, low lanes first.
- `mdr_out`  out  DATA_W  MDR contents.
- `busy`  out  1  high while in READ or WRITE.
- `done`  out  1  one-cycle pulse after a successful ack.
- `err`  out  1  sticky timeout flag.

## Operation

- The FSM has three states: IDLE, READ and WRITE.
- **IDLE** accepts commands with priority `mdr_in` > `rd_req` > `wr_req`; at most one command is accepted per cycle.
  - `mdr_in`: MDR is loaded with `bus_in`; state stays IDLE.
  - `rd_req`: go to READ; latch `size` and `sign_ext`; clear `err`.
  - `wr_req`: go to WRITE; latch `size`; clear `err`.
- **Commands while busy:** `mdr_in`, `rd_req` and `wr_req` are ignored in READ and WRITE. They are not queued.
- **READ** holds `mem_rd` = 1 and `mem_be` per the latched size.
  - On `mem_ack`, MDR is loaded with the sized and extended value of `mem_rdata`.
  - Byte takes bits [7:0]; half takes bits [15:0]; full takes all bits.
  - Extension uses the top bit of the selected field when `sign_ext` = 1, otherwise zeros.
  - Then return to IDLE and pulse `done`.
- **WRITE** holds `mem_wr` = 1, `mem_wdata` = MDR and `mem_be` per the latched size.
  - On `mem_ack`, return to IDLE and pulse `done`. MDR is unchanged.
- **Sizing / byte enables:**
  - Byte gives `mem_be` = 1 (lane 0 only).
  - Half gives `mem_be` = 3.
  - Full gives all ones.
  - `mem_be` is 0 in IDLE.
- **Timeout:**
  - A wait counter is cleared on entry to READ or WRITE and increments every cycle without `mem_ack`.
  - If the TIMEOUT-th wait cycle ends without ack, the transaction aborts: go to IDLE, set `err` = 1, keep the MDR unchanged, no `done`.
  - If ack arrives on that same edge, ack wins: normal completion, no error.
- **`mem_ack` outside a transaction:** ignored while in IDLE.
- **`err`:** stays high until the next accepted `rd_req` or `wr_req`, or until reset.
- **Reset** is asynchronous, any state, including mid-transaction:
  - State goes to IDLE; MDR and the counter go to 0.
  - `mem_rd`, `mem_wr`, `mem_be`, `busy`, `done` and `err` go to 0.
  - `mem_wdata` and `mdr_out` go to 0.
  - An in-flight transaction is dropped without `done`.

## Timing

- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- **`mdr_in` load:** `mdr_out` shows `bus_in` after the sampling edge (1-cycle latency).
- **Read, minimum path** (request sampled at edge E0):
  - `mem_rd` and `busy` go high after E0.
  - With ack sampled at E1: `mdr_out` is updated, `done` = 1, and `mem_rd` and `busy` drop, all after E1.
  - Minimum request-to-data latency is 2 edges.
- **Back-to-back:** a new request can be accepted in the `done` cycle, since the state is IDLE.
- **Write:** same handshake timing as read.
- **Timeout:** with request at E0 and no ack, the abort edge is E0+TIMEOUT. `err` rises and `busy` drops after that edge.
- **Reset:** asserting `reset` low forces outputs to their reset values immediately. Release is sampled synchronously; the first command can be accepted on the first edge after release.

## Test plan

- **Reset mid-transaction:** start a read, leave ack low, pulse `reset` low mid-wait -> `mem_rd` = 0, `busy` = 0, `mdr_out` = 0 immediately; no `done` pulse.
- **Byte load with sign extension:** `rd_req`, `size` = 0, `sign_ext` = 1, ack after 3 cycles with `mem_rdata` = 0x1234_5680 -> `mdr_out` = 0xFFFF_FF80, `done` for exactly 1 cycle, `mem_be` = 0x1 during the wait.
- **Half load, zero extension, same-cycle ack:** `size` = 1, `sign_ext` = 0, ack on the first wait cycle with 0xABCD_8001 -> `mdr_out` = 0x0000_8001 two edges after the request.
- **Full write:** `mdr_in` with `bus_in` = 0xDEAD_BEEF, then `wr_req` with `size` = 2 -> `mem_wr` = 1, `mem_wdata` = 0xDEAD_BEEF, `mem_be` = 0xF until ack; then `done`, and MDR still 0xDEAD_BEEF.
- **Timeout:** TIMEOUT = 15, `rd_req`, no ack -> abort at request edge + 15, `err` = 1, MDR unchanged. A following `wr_req` clears `err`. In a separate run, ack exactly on edge 15 -> completion with `err` = 0.
- **Priority and ignore:** `mdr_in`, `rd_req` and `wr_req` asserted together in IDLE -> only the bus load occurs. `rd_req` asserted during WRITE -> ignored. `mem_ack` in IDLE -> no state change.
